// File: rtl/flash_cmd_sequencer.sv
// Host-command to flash-controller request engine: unlock/command write cycles,
// DQ7/DQ5 status polling with timeout, and an F0 reset write on failure.
module flash_cmd_sequencer #(
  parameter logic [21:0] UNLOCK_ADDR1 = 22'hAAA,
  parameter logic [21:0] UNLOCK_ADDR2 = 22'h555,
  parameter logic [27:0] POLL_LIMIT   = 28'd200000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cmd,
  input  logic [21:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data,
  output logic [21:0] m_address,
  output logic [7:0]  m_to_mem,
  output logic        m_wren,
  output logic        m_req,
  input  logic [7:0]  m_from_mem,
  input  logic        m_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_POLL_ISSUE,
    ST_POLL_WAIT,
    ST_ABORT_ISSUE,
    ST_ABORT_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [1:0] CMD_READ       = 2'd0;
  localparam logic [1:0] CMD_PROGRAM    = 2'd1;
  localparam logic [1:0] CMD_CHIP_ERASE = 2'd3;

  state_t      state_reg, state_next;
  logic [2:0]  step_reg, step_next;
  logic [27:0] poll_cnt_reg, poll_cnt_next;
  logic        dq5_armed_reg, dq5_armed_next;
  logic [1:0]  cmd_reg, cmd_next;
  logic [21:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;
  logic [7:0]  rd_data_reg, rd_data_next;
  logic [21:0] m_address_reg, m_address_next;
  logic [7:0]  m_to_mem_reg, m_to_mem_next;
  logic        m_wren_reg, m_wren_next;
  logic        m_req_reg, m_req_next;

  logic [21:0] step_addr;
  logic [7:0]  step_data;
  logic        step_last;
  logic        poll_expect_msb;
  logic [27:0] poll_cnt_inc;

  // Write-cycle table for the latched command; the last step targets the user address
  // (or the chip-erase confirm cycle) and is followed by status polling.
  always_comb begin
    step_addr = UNLOCK_ADDR1;
    step_data = 8'hAA;
    step_last = 1'b0;
    if (cmd_reg == CMD_PROGRAM) begin
      case (step_reg)
        3'd0: begin step_addr = UNLOCK_ADDR1; step_data = 8'hAA; end
        3'd1: begin step_addr = UNLOCK_ADDR2; step_data = 8'h55; end
        3'd2: begin step_addr = UNLOCK_ADDR1; step_data = 8'hA0; end
        default: begin
          step_addr = addr_reg;
          step_data = data_reg;
          step_last = 1'b1;
        end
      endcase
    end else begin
      case (step_reg)
        3'd0: begin step_addr = UNLOCK_ADDR1; step_data = 8'hAA; end
        3'd1: begin step_addr = UNLOCK_ADDR2; step_data = 8'h55; end
        3'd2: begin step_addr = UNLOCK_ADDR1; step_data = 8'h80; end
        3'd3: begin step_addr = UNLOCK_ADDR1; step_data = 8'hAA; end
        3'd4: begin step_addr = UNLOCK_ADDR2; step_data = 8'h55; end
        default: begin
          step_last = 1'b1;
          if (cmd_reg == CMD_CHIP_ERASE) begin
            step_addr = UNLOCK_ADDR1;
            step_data = 8'h10;
          end else begin
            step_addr = addr_reg;
            step_data = 8'h30;
          end
        end
      endcase
    end
  end

  assign poll_expect_msb = (cmd_reg == CMD_PROGRAM) ? data_reg[7] : 1'b1;
  assign poll_cnt_inc    = poll_cnt_reg + 28'd1;

  // Every request is launched from an *_ISSUE state, so m_req is always preceded by
  // at least one low cycle after the previous m_ready.
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    poll_cnt_next  = poll_cnt_reg;
    dq5_armed_next = dq5_armed_reg;
    cmd_next       = cmd_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    error_next     = error_reg;
    rd_data_next   = rd_data_reg;
    m_address_next = m_address_reg;
    m_to_mem_next  = m_to_mem_reg;
    m_wren_next    = m_wren_reg;
    m_req_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !busy_reg) begin
          cmd_next       = cmd;
          addr_next      = cmd_addr;
          data_next      = cmd_data;
          step_next      = 3'd0;
          poll_cnt_next  = 28'd0;
          dq5_armed_next = 1'b0;
          busy_next      = 1'b1;
          error_next     = 1'b0;
          state_next     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        m_req_next = 1'b1;
        if (cmd_reg == CMD_READ) begin
          m_address_next = addr_reg;
          m_to_mem_next  = 8'h00;
          m_wren_next    = 1'b0;
        end else begin
          m_address_next = step_addr;
          m_to_mem_next  = step_data;
          m_wren_next    = 1'b1;
        end
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (m_ready) begin
          if (cmd_reg == CMD_READ) begin
            rd_data_next = m_from_mem;
            done_next    = 1'b1;
            state_next   = ST_FINISH;
          end else if (step_last) begin
            state_next = ST_POLL_ISSUE;
          end else begin
            step_next  = step_reg + 3'd1;
            state_next = ST_ISSUE;
          end
        end
      end

      ST_POLL_ISSUE: begin
        m_req_next     = 1'b1;
        m_address_next = addr_reg;
        m_to_mem_next  = 8'h00;
        m_wren_next    = 1'b0;
        state_next     = ST_POLL_WAIT;
      end

      ST_POLL_WAIT: begin
        if (m_ready) begin
          poll_cnt_next = poll_cnt_inc;
          if (m_from_mem[7] == poll_expect_msb) begin
            done_next  = 1'b1;
            state_next = ST_FINISH;
          end else if (dq5_armed_reg || (poll_cnt_inc >= POLL_LIMIT)) begin
            // DQ5 confirmation read still mismatching, or out of poll budget
            error_next = 1'b1;
            state_next = ST_ABORT_ISSUE;
          end else begin
            dq5_armed_next = m_from_mem[5];
            state_next     = ST_POLL_ISSUE;
          end
        end
      end

      ST_ABORT_ISSUE: begin
        m_req_next     = 1'b1;
        m_address_next = UNLOCK_ADDR1;
        m_to_mem_next  = 8'hF0;
        m_wren_next    = 1'b1;
        state_next     = ST_ABORT_WAIT;
      end

      ST_ABORT_WAIT: begin
        if (m_ready) begin
          done_next  = 1'b1;
          state_next = ST_FINISH;
        end
      end

      ST_FINISH: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      step_reg      <= 3'd0;
      poll_cnt_reg  <= 28'd0;
      dq5_armed_reg <= 1'b0;
      cmd_reg       <= 2'd0;
      addr_reg      <= 22'd0;
      data_reg      <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      rd_data_reg   <= 8'd0;
      m_address_reg <= 22'd0;
      m_to_mem_reg  <= 8'd0;
      m_wren_reg    <= 1'b0;
      m_req_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      poll_cnt_reg  <= poll_cnt_next;
      dq5_armed_reg <= dq5_armed_next;
      cmd_reg       <= cmd_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      rd_data_reg   <= rd_data_next;
      m_address_reg <= m_address_next;
      m_to_mem_reg  <= m_to_mem_next;
      m_wren_reg    <= m_wren_next;
      m_req_reg     <= m_req_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign rd_data   = rd_data_reg;
  assign m_address = m_address_reg;
  assign m_to_mem  = m_to_mem_reg;
  assign m_wren    = m_wren_reg;
  assign m_req     = m_req_reg;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Randomized bench for flash_cmd_sequencer: a flash-controller responder, a
// sequence-level model of expected bus traffic, and a per-cycle protocol monitor.
module tb_flash_cmd_sequencer;

  localparam logic [21:0] A1 = 22'hAAA;
  localparam logic [21:0] A2 = 22'h555;
  localparam int          LIMIT = 5;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd;
  logic [21:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  rd_data;
  logic [21:0] m_address;
  logic [7:0]  m_to_mem;
  logic        m_wren;
  logic        m_req;
  logic [7:0]  m_from_mem;
  logic        m_ready;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic        wren;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       log_q[$];
  logic [7:0] resp_q[$];

  int         vectors = 0;
  int         miscompares = 0;
  logic       exp_busy = 1'b0;
  logic       exp_err = 1'b0;
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] rd_model = 8'h00;
  logic       last_err = 1'b0;

  flash_cmd_sequencer #(
    .UNLOCK_ADDR1(22'hAAA),
    .UNLOCK_ADDR2(22'h555),
    .POLL_LIMIT(28'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .start(start),
    .busy(busy),
    .done(done),
    .error(error),
    .rd_data(rd_data),
    .m_address(m_address),
    .m_to_mem(m_to_mem),
    .m_wren(m_wren),
    .m_req(m_req),
    .m_from_mem(m_from_mem),
    .m_ready(m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input logic [21:0] a, input logic [7:0] d, input logic w);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.wren = w;
    exp_q.push_back(t);
  endfunction

  // Expected bus traffic, final error and rd_data from the command and the status bytes
  // the responder will hand back.
  task automatic build_model(input logic [1:0] c, input logic [21:0] a, input logic [7:0] d);
    logic [7:0] want;
    bit armed;
    bit fin;
    bit fail;
    exp_q.delete();
    exp_err = 1'b0;
    exp_rd = rd_model;
    if (c == 2'd0) begin
      push_exp(a, 8'h00, 1'b0);
      exp_rd = resp_q[0];
      return;
    end
    push_exp(A1, 8'hAA, 1'b1);
    push_exp(A2, 8'h55, 1'b1);
    if (c == 2'd1) begin
      push_exp(A1, 8'hA0, 1'b1);
      push_exp(a, d, 1'b1);
      want = d;
    end else begin
      push_exp(A1, 8'h80, 1'b1);
      push_exp(A1, 8'hAA, 1'b1);
      push_exp(A2, 8'h55, 1'b1);
      if (c == 2'd2) push_exp(a, 8'h30, 1'b1);
      else push_exp(A1, 8'h10, 1'b1);
      want = 8'hFF;
    end
    armed = 1'b0;
    fin = 1'b0;
    fail = 1'b0;
    for (int i = 0; i < resp_q.size() && !fin; i++) begin
      push_exp(a, 8'h00, 1'b0);
      if (resp_q[i][7] == want[7]) fin = 1'b1;
      else if (armed || (i + 1) >= LIMIT) begin
        fin = 1'b1;
        fail = 1'b1;
      end else armed = resp_q[i][5];
    end
    if (!fin) fail = 1'b1;
    if (fail) begin
      push_exp(A1, 8'hF0, 1'b1);
      exp_err = 1'b1;
    end
  endtask

  task automatic gen_polls(input logic want7);
    logic [7:0] b;
    resp_q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 6))
        0, 1: b[7] = want7;
        2: begin b[7] = ~want7; b[5] = 1'b1; end
        default: begin b[7] = ~want7; b[5] = 1'b0; end
      endcase
      resp_q.push_back(b);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [21:0] a, input logic [7:0] d);
    bit got;
    int gap;
    build_model(c, a, d);
    log_q.delete();
    @(posedge clk); #1;
    check("err_hold_before_start", 32'(error), 32'(last_err));
    cmd = c;
    cmd_addr = a;
    cmd_data = d;
    start = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    check("busy_on_accept", 32'(busy), 1);
    check("err_clear_on_accept", 32'(error), 0);
    got = 1'b0;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      start = 1'($urandom_range(0, 1));
      cmd = 2'($urandom);
      cmd_addr = 22'($urandom);
      cmd_data = 8'($urandom);
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in 400 cycles, expected one done pulse (cmd %0d)", c);
      rst = 1'b1;
      start = 1'b0;
      exp_busy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rd_model = 8'h00;
      last_err = 1'b0;
      resp_q.delete();
      return;
    end
    check("done_error", 32'(error), 32'(exp_err));
    check("done_rd_data", 32'(rd_data), 32'(exp_rd));
    check("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("txn%0d_addr", i), 32'(log_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("txn%0d_wren", i), 32'(log_q[i].wren), 32'(exp_q[i].wren));
      if (exp_q[i].wren) check($sformatf("txn%0d_data", i), 32'(log_q[i].data), 32'(exp_q[i].data));
    end
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_after_finish", 32'(busy), 0);
    check("err_after_finish", 32'(error), 32'(exp_err));
    gap = $urandom_range(1, 3);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("err_sticky_idle", 32'(error), 32'(exp_err));
    end
    $display("cmd %0d addr 0x%06h data 0x%02h: %0d bus cycles, error %0b, rd_data 0x%02h",
             c, a, d, log_q.size(), error, rd_data);
    resp_q.delete();
    last_err = exp_err;
    rd_model = exp_rd;
  endtask

  // Flash-controller responder: logs each request, holds m_ready off for a random
  // latency while checking the request stays stable, and injects stray m_ready when idle.
  initial begin
    txn_t t;
    bit aborted;
    int lat;
    m_ready = 1'b0;
    m_from_mem = 8'h00;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      if (!rst && m_req) begin
        t.addr = m_address;
        t.data = m_to_mem;
        t.wren = m_wren;
        log_q.push_back(t);
        aborted = 1'b0;
        lat = $urandom_range(1, 4);
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          check("req_addr_stable", 32'(m_address), 32'(t.addr));
          check("req_data_stable", 32'(m_to_mem), 32'(t.data));
          check("req_wren_stable", 32'(m_wren), 32'(t.wren));
        end
        if (!aborted) begin
          if (!t.wren) m_from_mem = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
          else m_from_mem = 8'($urandom);
          m_ready = 1'b1;
        end
      end else if (!rst && !busy && $urandom_range(0, 7) == 0) begin
        m_from_mem = 8'($urandom);
        m_ready = 1'b1;
      end
    end
  end

  // Per-cycle protocol monitor.
  initial begin
    logic prev_req;
    logic prev_rdy;
    prev_req = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("req_not_adjacent", 32'(m_req && prev_req), 0);
        check("req_gap_after_ready", 32'(m_req && prev_rdy), 0);
        check("busy_level", 32'(busy), 32'(exp_busy));
        check("done_implies_busy", 32'(done && !busy), 0);
        check("req_implies_busy", 32'(m_req && !busy), 0);
        prev_req = m_req;
        prev_rdy = m_ready;
      end else begin
        prev_req = 1'b0;
        prev_rdy = 1'b0;
      end
    end
  end

  initial begin
    logic [1:0]  c;
    logic [21:0] a;
    logic [7:0]  d;
    bit          got;
    bit          req_seen;
    rst = 1'b1;
    start = 1'b0;
    cmd = 2'd0;
    cmd_addr = 22'd0;
    cmd_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_m_address", 32'(m_address), 0);
    check("rst_m_to_mem", 32'(m_to_mem), 0);
    check("rst_m_wren", 32'(m_wren), 0);
    check("rst_m_req", 32'(m_req), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    resp_q = '{8'h5A};
    run_cmd(2'd0, 22'h123456, 8'h00);
    check("read_rd_literal", 32'(rd_data), 'h5A);
    check("read_model_len", exp_q.size(), 1);

    resp_q = '{8'h9C, 8'h9C, 8'h9C, 8'h3C};
    run_cmd(2'd1, 22'h000010, 8'h3C);
    check("prog_model_len", exp_q.size(), 8);
    check("prog_error_literal", 32'(error), 0);

    resp_q = '{8'h00, 8'h00, 8'hFF};
    run_cmd(2'd2, 22'h010000, 8'h00);
    check("sector_model_len", exp_q.size(), 9);
    check("sector_rd_unchanged", 32'(rd_data), 'h5A);

    resp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_cmd(2'd3, 22'h000100, 8'h00);
    check("timeout_model_len", exp_q.size(), 12);
    check("timeout_error_literal", 32'(error), 1);

    resp_q = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    run_cmd(2'd1, 22'h000200, 8'h80);
    check("dq5_fail_model_len", exp_q.size(), 7);
    check("dq5_fail_error_literal", 32'(error), 1);

    resp_q = '{8'h20, 8'h80};
    run_cmd(2'd1, 22'h000200, 8'h80);
    check("dq5_recover_model_len", exp_q.size(), 6);
    check("dq5_recover_error_literal", 32'(error), 0);

    // Asynchronous reset while the second unlock write is outstanding.
    resp_q.delete();
    log_q.delete();
    @(posedge clk); #1;
    cmd = 2'd1;
    cmd_addr = 22'h000020;
    cmd_data = 8'h11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= 2) got = 1'b1;
    end
    check("rst_test_reached_wait", 32'(got), 1);
    #1;
    rst = 1'b1;
    exp_busy = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_error", 32'(error), 0);
    check("async_rst_rd_data", 32'(rd_data), 0);
    check("async_rst_m_address", 32'(m_address), 0);
    check("async_rst_m_to_mem", 32'(m_to_mem), 0);
    check("async_rst_m_wren", 32'(m_wren), 0);
    check("async_rst_m_req", 32'(m_req), 0);
    $display("async reset during write cycle %0d: outputs cleared", log_q.size());
    rd_model = 8'h00;
    last_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (m_req) req_seen = 1'b1;
    end
    check("no_req_after_rst", 32'(req_seen), 0);

    resp_q = '{8'hC3};
    run_cmd(2'd0, 22'h2AAAAA, 8'h00);
    check("read_after_rst_literal", 32'(rd_data), 'hC3);

    for (int n = 0; n < 40; n++) begin
      c = 2'($urandom_range(0, 3));
      a = 22'($urandom);
      d = 8'($urandom);
      resp_q.delete();
      if (c == 2'd0) resp_q.push_back(8'($urandom));
      else gen_polls((c == 2'd1) ? d[7] : 1'b1);
      run_cmd(c, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
